// File: rtl/chu_debounce_pkg.sv
// rtl/chu_debounce_pkg.sv - shared register offsets for the debounce slot core
//
// Purpose: word offsets of the slot registers, imported by the core.
// Ports:   none (package).
package chu_debounce_pkg;

  localparam logic [4:0] DB_REG_RAW  = 5'd0;  // synchronized raw inputs
  localparam logic [4:0] DB_REG_DB   = 5'd1;  // debounced level
  localparam logic [4:0] DB_REG_RISE = 5'd2;  // sticky rising-edge capture, W1C
  localparam logic [4:0] DB_REG_FALL = 5'd3;  // sticky falling-edge capture, W1C (optional)

endpackage

// File: rtl/chu_debounce_core_bit.sv
// rtl/chu_debounce_core_bit.sv - per-bit debounce counter and accepted level
//
// Purpose: accepts a new level only after STABLE consecutive sample ticks
//          disagree with the current level; any agreeing tick restarts.
// Ports:
//   clk        in  system clock
//   reset      in  synchronous, active-high
//   tick_i     in  one-cycle sample strobe from the prescaler
//   sample_i   in  synchronized input bit
//   db_o       out current debounced level (registered)
//   db_next_o  out level the register takes on the next edge, so the
//                  parent can capture edges in the same cycle db changes
module debounce_bit #(
  parameter int STABLE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic sample_i,
  output logic db_o,
  output logic db_next_o
);

  localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (tick_i) begin
      if (sample_i == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(STABLE - 1)) begin
        db_d  = sample_i;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db_o      = db_q;
  assign db_next_o = db_d;

endmodule

// File: rtl/chu_debounce_core.sv
// rtl/chu_debounce_core.sv - MMIO slot core debouncing W raw button/switch inputs
//
// Purpose: synchronizes din, debounces each bit on a prescaled sample tick,
//          captures sticky rising edges and exposes them on the slot bus.
// Config:  define DB_FALL_EDGE_EN to add a sticky falling-edge register at
//          address 3; otherwise address 3 reads 0 and ignores writes.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous, active-high
//   cs       in  slot select
//   read     in  read strobe (reads have no side effects, so it is unused)
//   write    in  write strobe
//   addr     in  [4:0] word address
//   rd_data  out [31:0] read data, combinational from addr
//   wr_data  in  [31:0] write data
//   din      in  [W-1:0] raw asynchronous inputs
module chu_debounce_core
  import chu_debounce_pkg::*;
#(
  parameter int W        = 8,
  parameter int TICK_DIV = 50000,
  parameter int STABLE   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  output logic [31:0]  rd_data,
  input  logic [31:0]  wr_data,
  input  logic [W-1:0] din
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0]  sync1_q, sync2_q;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic [W-1:0]  db, db_next;
  logic [W-1:0]  rise_q, rise_d, rise_clr;
  logic          unused_bus;

  // Strobes and upper write bits carry no meaning for this core.
  assign unused_bus = ^{read, wr_data};

  assign tick  = (pre_q == PW'(TICK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pre_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      pre_q   <= pre_d;
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_bit
    debounce_bit #(.STABLE(STABLE)) u_bit (
      .clk       (clk),
      .reset     (reset),
      .tick_i    (tick),
      .sample_i  (sync2_q[i]),
      .db_o      (db[i]),
      .db_next_o (db_next[i])
    );
  end

  // Set is OR-ed after the clear so a new edge survives a same-cycle W1C.
  assign rise_clr = (cs && write && addr == DB_REG_RISE) ? wr_data[W-1:0] : '0;
  assign rise_d   = (rise_q & ~rise_clr) | (db_next & ~db);

  always_ff @(posedge clk) begin
    if (reset) rise_q <= '0;
    else       rise_q <= rise_d;
  end

`ifdef DB_FALL_EDGE_EN
  logic [W-1:0] fall_q, fall_d, fall_clr;

  assign fall_clr = (cs && write && addr == DB_REG_FALL) ? wr_data[W-1:0] : '0;
  assign fall_d   = (fall_q & ~fall_clr) | (~db_next & db);

  always_ff @(posedge clk) begin
    if (reset) fall_q <= '0;
    else       fall_q <= fall_d;
  end
`endif

  always_comb begin
    rd_data = '0;
    case (addr)
      DB_REG_RAW:  rd_data = 32'(sync2_q);
      DB_REG_DB:   rd_data = 32'(db);
      DB_REG_RISE: rd_data = 32'(rise_q);
`ifdef DB_FALL_EDGE_EN
      DB_REG_FALL: rd_data = 32'(fall_q);
`endif
      default:     rd_data = '0;
    endcase
  end

endmodule
